// File: rtl/frogger_pkg.sv
// Shared types and helpers for the Frogger lane logic.
package frogger_pkg;

  typedef enum logic {GAP = 1'b0, CAR = 1'b1} lane_state_t;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

  // Counter width able to hold max(car_len, min_gap) without wrapping.
  function automatic int unsigned cnt_width(input int unsigned car_len, input int unsigned min_gap);
    int unsigned top;
    top = (car_len > min_gap) ? car_len : min_gap;
    return (top < 1) ? 1 : $clog2(top + 1);
  endfunction

endpackage

// File: rtl/lane_spawner.sv
// One Frogger traffic lane: scrolling occupancy row fed by a gap/car-length spawn FSM.
module lane_spawner
  import frogger_pkg::*;
#(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned CAR_LEN      = 3,
  parameter int unsigned MIN_GAP      = 2,
  parameter logic [8:0]  SPAWN_THRESH = 9'd170,
  parameter logic        DIR          = DIR_DOWN
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tick,
  input  logic             freeze,
  input  logic [8:0]       random,
  output logic [WIDTH-1:0] row,
  output logic             spawn
);

  localparam int unsigned CNT_W = cnt_width(CAR_LEN, MIN_GAP);

  lane_state_t      state_q, state_d;
  logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0] car_cnt_q, car_cnt_d;
  logic [CNT_W-1:0] car_inc;
  logic [WIDTH-1:0] row_q, row_d;
  logic             spawn_q, spawn_d;
  logic             new_cell;

  // Next entering cell and FSM step; everything holds unless a tick is accepted.
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    car_cnt_d = car_cnt_q;
    row_d     = row_q;
    spawn_d   = 1'b0;
    new_cell  = 1'b0;
    car_inc   = car_cnt_q + CNT_W'(1);

    if (tick && !freeze) begin
      case (state_q)
        GAP: begin
          if (gap_cnt_q < CNT_W'(MIN_GAP)) begin
            gap_cnt_d = gap_cnt_q + CNT_W'(1);
          end else if (random < SPAWN_THRESH) begin
            new_cell  = 1'b1;
            spawn_d   = 1'b1;
            car_cnt_d = CNT_W'(1);
            if (CAR_LEN == 1) begin
              gap_cnt_d = '0;
            end else begin
              state_d = CAR;
            end
          end
        end
        CAR: begin
          new_cell  = 1'b1;
          car_cnt_d = car_inc;
          if (car_inc == CNT_W'(CAR_LEN)) begin
            state_d   = GAP;
            gap_cnt_d = '0;
          end
        end
        default: state_d = GAP;
      endcase

      if (DIR == DIR_DOWN) begin
        row_d = {new_cell, row_q[WIDTH-1:1]};
      end else begin
        row_d = {row_q[WIDTH-2:0], new_cell};
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= GAP;
      gap_cnt_q <= '0;
      car_cnt_q <= '0;
      row_q     <= '0;
      spawn_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      car_cnt_q <= car_cnt_d;
      row_q     <= row_d;
      spawn_q   <= spawn_d;
    end
  end

  assign row   = row_q;
  assign spawn = spawn_q;

endmodule

// File: tb/tb_lane_spawner.sv
// Randomized bench for lane_spawner: run-length reference model plus directed edge cases.
module tb_lane_spawner;
  import frogger_pkg::*;

  localparam int unsigned W  = 16;
  localparam int unsigned CL = 3;
  localparam int unsigned MG = 2;
  localparam int unsigned TH = 170;

  logic         clock  = 1'b0;
  logic         reset  = 1'b0;
  logic         tick   = 1'b0;
  logic         freeze = 1'b0;
  logic [8:0]   random = '0;
  logic [W-1:0] row_dn, row_up;
  logic         spawn_dn, spawn_up;

  always #5 clock = ~clock;

  lane_spawner #(.WIDTH(W), .CAR_LEN(CL), .MIN_GAP(MG), .SPAWN_THRESH(9'd170), .DIR(DIR_DOWN)) dut_dn (
    .clock(clock), .reset(reset), .tick(tick), .freeze(freeze), .random(random),
    .row(row_dn), .spawn(spawn_dn)
  );

  lane_spawner #(.WIDTH(W), .CAR_LEN(CL), .MIN_GAP(MG), .SPAWN_THRESH(9'd170), .DIR(DIR_UP)) dut_up (
    .clock(clock), .reset(reset), .tick(tick), .freeze(freeze), .random(random),
    .row(row_up), .spawn(spawn_up)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: lane expressed as trailing run lengths of the inserted stream.
  logic [W-1:0] m_dn, m_up;
  logic         m_spawn;
  int           ones_run, zeros_run;

  task automatic model_reset();
    m_dn = '0; m_up = '0; m_spawn = 1'b0; ones_run = 0; zeros_run = 0;
  endtask

  task automatic model_tick(input logic [8:0] rnd);
    logic c;
    if (ones_run > 0 && ones_run < CL)       c = 1'b1;
    else if (ones_run >= CL)                 c = 1'b0;
    else if (zeros_run < MG)                 c = 1'b0;
    else                                     c = (int'(rnd) < TH);
    m_spawn = c && (ones_run == 0);
    if (c) begin ones_run++; zeros_run = 0; end
    else   begin zeros_run++; ones_run = 0; end
    m_dn = {c, m_dn[W-1:1]};
    m_up = {m_up[W-2:0], c};
  endtask

  // Observed run-length scoreboard, index 0 = down lane, 1 = up lane.
  int obs_val[2], obs_len[2], n_cars[2];
  bit obs_lead[2];

  task automatic track_reset();
    for (int k = 0; k < 2; k++) begin
      obs_val[k] = 0; obs_len[k] = 0; obs_lead[k] = 1'b1; n_cars[k] = 0;
    end
  endtask

  task automatic track(input int k, input logic c);
    if (obs_len[k] == 0) begin
      obs_val[k] = int'(c); obs_len[k] = 1;
    end else if (int'(c) == obs_val[k]) begin
      obs_len[k]++;
    end else begin
      if (obs_val[k] == 1) begin
        check_eq($sformatf("run1_len[%0d]", k), 32'(obs_len[k]), 32'(CL));
        n_cars[k]++;
      end else if (!obs_lead[k]) begin
        check_eq($sformatf("run0_min[%0d]", k), 32'(obs_len[k] >= MG), 32'd1);
      end
      obs_lead[k] = 1'b0;
      obs_val[k]  = int'(c);
      obs_len[k]  = 1;
    end
  endtask

  // One clock: drive at negedge, sample just after posedge, compare both lanes to the model.
  task automatic cycle(input logic tk, input logic fr, input logic [8:0] rnd, input string tag);
    @(negedge clock);
    tick = tk; freeze = fr; random = rnd;
    @(posedge clock);
    #1;
    if (tk && !fr) model_tick(rnd);
    else           m_spawn = 1'b0;
    check_eq({tag, ".row_dn"},   32'(row_dn),   32'(m_dn));
    check_eq({tag, ".row_up"},   32'(row_up),   32'(m_up));
    check_eq({tag, ".spawn_dn"}, 32'(spawn_dn), 32'(m_spawn));
    check_eq({tag, ".spawn_up"}, 32'(spawn_up), 32'(m_spawn));
    tick = 1'b0;
  endtask

  // Asynchronous reset asserted between clock edges, released on a falling edge.
  task automatic do_reset(input string tag);
    @(posedge clock);
    #3 reset = 1'b0;
    #1;
    check_eq({tag, ".rst_row_dn"}, 32'(row_dn),   32'd0);
    check_eq({tag, ".rst_row_up"}, 32'(row_up),   32'd0);
    check_eq({tag, ".rst_spawn"},  32'(spawn_dn), 32'd0);
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    logic [7:0] sp;
    logic [W-1:0] saved;
    logic any_spawn;
    logic [8:0] lfsr;
    int first;

    model_reset();
    track_reset();
    #12;
    check_eq("reset.row_dn", 32'(row_dn), 32'd0);
    check_eq("reset.spawn",  32'(spawn_dn), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // 1: random pinned at 0
    sp = '0;
    for (int t = 0; t < 8; t++) begin
      cycle(1'b1, 1'b0, 9'd0, "t1");
      sp[t] = spawn_dn;
    end
    check_eq("t1.row_top", 32'(row_dn[15:8]), 32'h9C);
    check_eq("t1.spawn_ticks", 32'(sp), 32'h84);

    // 2: random pinned at 511, never spawns
    do_reset("t2");
    any_spawn = 1'b0;
    for (int t = 0; t < 40; t++) begin
      cycle(1'b1, 1'b0, 9'd511, "t2");
      any_spawn |= spawn_dn;
    end
    check_eq("t2.row", 32'(row_dn), 32'd0);
    check_eq("t2.spawn", 32'(any_spawn), 32'd0);

    // 3: threshold edge once the gap is satisfied
    do_reset("t3");
    for (int t = 0; t < 3; t++) cycle(1'b1, 1'b0, 9'd511, "t3");
    cycle(1'b1, 1'b0, 9'd170, "t3_170");
    check_eq("t3.at170_cell", 32'(row_dn[15]), 32'd0);
    check_eq("t3.at170_spawn", 32'(spawn_dn), 32'd0);
    cycle(1'b1, 1'b0, 9'd169, "t3_169");
    check_eq("t3.at169_cell", 32'(row_dn[15]), 32'd1);
    check_eq("t3.at169_spawn", 32'(spawn_dn), 32'd1);

    // 4: freeze mid-car, then car completes at exactly three cells
    saved = row_dn;
    for (int t = 0; t < 5; t++) cycle(1'b1, 1'b1, 9'd0, "t4_frz");
    check_eq("t4.frozen_row", 32'(row_dn), 32'(saved));
    cycle(1'b1, 1'b0, 9'd511, "t4");
    cycle(1'b1, 1'b0, 9'd511, "t4");
    check_eq("t4.car3", 32'(row_dn[15:13]), 32'h7);
    cycle(1'b1, 1'b0, 9'd0, "t4");
    check_eq("t4.car_end", 32'(row_dn[15:12]), 32'h7);

    // 5: reset mid-car, then first spawn must be on tick 3
    do_reset("t5a");
    for (int t = 0; t < 4; t++) cycle(1'b1, 1'b0, 9'd0, "t5a");
    do_reset("t5");
    first = 0;
    for (int t = 1; t <= 6; t++) begin
      cycle(1'b1, 1'b0, 9'd0, "t5");
      if (spawn_dn && first == 0) first = t;
    end
    check_eq("t5.first_spawn", 32'(first), 32'd3);

    // 6: LFSR-driven, random tick spacing and occasional frozen ticks
    do_reset("t6");
    track_reset();
    lfsr = 9'h1;
    for (int n = 0; n < 2000; n++) begin
      int idle;
      idle = int'($urandom_range(0, 3));
      for (int i = 0; i < idle; i++) cycle(1'b0, 1'b0, lfsr, "t6_idle");
      if ($urandom_range(0, 9) == 0) cycle(1'b1, 1'b1, lfsr, "t6_frz");
      cycle(1'b1, 1'b0, lfsr, "t6");
      track(0, row_dn[W-1]);
      track(1, row_up[0]);
      lfsr = {lfsr[7:0], lfsr[8] ^ lfsr[4]};
    end
    check_eq("t6.cars_dn", 32'(n_cars[0] > 50), 32'd1);
    check_eq("t6.cars_up", 32'(n_cars[1]), 32'(n_cars[0]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
